// File: rtl/score_bcd_if.sv
// score_bcd_if: binary score in, packed BCD out.
// Master drives value/start; slave returns status and result.
interface score_bcd_if #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
);
  logic [BIN_WIDTH-1:0] value;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd;
  logic                 overflow;

  modport master (
    output value, start,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  value, start,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: serial double-dabble, one bit per clock.
// Optional SCORE_BCD_AUTO_REFRESH_EN reconverts whenever value changes.
module score_bcd_converter #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  score_bcd_if.slave  bus
);
  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(BIN_WIDTH+1);
  localparam logic [31:0] MAX_VALUE = 32'(10**DIGITS - 1);
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  state_t               state_nx;
  logic [BIN_WIDTH-1:0] binary;
  logic [W:0]           scratch;
  logic [W:0]           scratch_nx;
  logic [W-1:0]         adj;
  logic [CW-1:0]        cnt;
  logic                 ovf_flag;
  logic                 trig;
  logic                 accept;
  logic                 last;
  logic                 sat;
  logic [W-1:0]         bcd_q;
  logic                 ovf_q;

`ifdef SCORE_BCD_AUTO_REFRESH_EN
  logic [BIN_WIDTH-1:0] last_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_value <= '0;
    else if (accept)
      last_value <= bus.value;
  end

  assign trig = bus.start | (bus.value != last_value);
`else
  assign trig = bus.start;
`endif

  assign accept = (state != SHIFT) && trig;
  assign last   = (state == SHIFT) &&
                  (cnt == CW'(BIN_WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (trig) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = trig ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    adj = scratch[W-1:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    scratch_nx = {adj, binary[BIN_WIDTH-1]};
    // A carry out of the top digit also means the value cannot be shown
    sat = ovf_flag | scratch[W] | scratch_nx[W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      binary   <= bus.value;
      scratch  <= '0;
      cnt      <= '0;
      ovf_flag <= 32'(bus.value) > MAX_VALUE;
    end else if (state == SHIFT) begin
      binary  <= binary << 1;
      scratch <= scratch_nx;
      cnt     <= cnt + CW'(1);
      if (last) begin
        bcd_q <= sat ? NINES : scratch_nx[W-1:0];
        ovf_q <= ovf_flag;
      end
    end
  end

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter: directed vectors for the BCD converter.
// Expected values are hand-computed constants.
module tb_score_bcd_converter;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;
  int   busy_n;
  int   dones;

  score_bcd_if #(.BIN_WIDTH(14), .DIGITS(4)) bus ();

  score_bcd_converter #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [13:0] v);
    bus.value = v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    do begin
      tick();
      cycles++;
      if (bus.busy) busy_cnt++;
    end while (!bus.done && cycles < 40);
  endtask

  task automatic count_dones(input int len, output int cnt);
    cnt = 0;
    repeat (len) begin
      tick();
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.value = '0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_bcd", 32'(bus.bcd), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    rst_n = 1'b1;
    tick();

`ifdef SCORE_BCD_AUTO_REFRESH_EN
    bus.value = 14'd42;
    tick();
    check("auto_busy", 32'(bus.busy), 1);
    wait_done(n, busy_n);
    check("auto_done", 32'(bus.done), 1);
    check("auto_lat", 32'(n), 14);
    check("auto_bcd", 32'(bus.bcd), 32'h0042);
    count_dones(20, dones);
    check("auto_quiet", 32'(dones), 0);
    launch(14'd42);
    check("auto_force_busy", 32'(bus.busy), 1);
    wait_done(n, busy_n);
    check("auto_force_done", 32'(bus.done), 1);
    check("auto_force_lat", 32'(n), 14);
    check("auto_force_bcd", 32'(bus.bcd), 32'h0042);
    check("auto_force_ovf", 32'(bus.overflow), 0);
`else
    launch(14'd1234);
    check("t1_busy0", 32'(bus.busy), 1);
    check("t1_done0", 32'(bus.done), 0);
    wait_done(n, busy_n);
    check("t1_done", 32'(bus.done), 1);
    check("t1_lat", 32'(n), 14);
    check("t1_busycnt", 32'(busy_n + 1), 14);
    check("t1_bcd", 32'(bus.bcd), 32'h1234);
    check("t1_ovf", 32'(bus.overflow), 0);
    tick();
    check("t1_pulse", 32'(bus.done), 0);
    check("t1_hold", 32'(bus.bcd), 32'h1234);

    launch(14'd0);
    wait_done(n, busy_n);
    check("t2a_done", 32'(bus.done), 1);
    check("t2a_bcd", 32'(bus.bcd), 32'h0000);
    check("t2a_ovf", 32'(bus.overflow), 0);
    launch(14'd9999);
    wait_done(n, busy_n);
    check("t2b_bcd", 32'(bus.bcd), 32'h9999);
    check("t2b_ovf", 32'(bus.overflow), 0);
    launch(14'd10000);
    wait_done(n, busy_n);
    check("t2c_bcd", 32'(bus.bcd), 32'h9999);
    check("t2c_ovf", 32'(bus.overflow), 1);
    launch(14'd16383);
    wait_done(n, busy_n);
    check("t2d_bcd", 32'(bus.bcd), 32'h9999);
    check("t2d_ovf", 32'(bus.overflow), 1);
    launch(14'd2047);
    wait_done(n, busy_n);
    check("t2e_bcd", 32'(bus.bcd), 32'h2047);
    check("t2e_ovf", 32'(bus.overflow), 0);

    launch(14'd42);
    repeat (3) tick();
    bus.value = 14'd77;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t3_busy", 32'(bus.busy), 1);
    wait_done(n, busy_n);
    check("t3_done", 32'(bus.done), 1);
    check("t3_lat", 32'(n), 10);
    check("t3_bcd", 32'(bus.bcd), 32'h0042);
    count_dones(20, dones);
    check("t3_single", 32'(dones), 0);
    check("t3_idle", 32'(bus.busy), 0);

    bus.value = 14'd1;
    bus.start = 1'b1;
    tick();
    check("t4_busy", 32'(bus.busy), 1);
    wait_done(n, busy_n);
    check("t4a_lat", 32'(n), 14);
    check("t4a_bcd", 32'(bus.bcd), 32'h0001);
    bus.value = 14'd2;
    wait_done(n, busy_n);
    check("t4b_period", 32'(n), 15);
    check("t4b_busycnt", 32'(busy_n), 14);
    check("t4b_bcd", 32'(bus.bcd), 32'h0002);
    bus.value = 14'd3;
    wait_done(n, busy_n);
    check("t4c_period", 32'(n), 15);
    check("t4c_bcd", 32'(bus.bcd), 32'h0003);
    bus.start = 1'b0;
    tick();
    check("t4_end_done", 32'(bus.done), 0);
    check("t4_end_busy", 32'(bus.busy), 0);

    launch(14'd555);
    wait_done(n, busy_n);
    check("t5_bcd555", 32'(bus.bcd), 32'h0555);
    launch(14'd8888);
    repeat (6) tick();
    check("t5_busy_pre", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(bus.busy), 0);
    check("t5_rst_done", 32'(bus.done), 0);
    check("t5_rst_bcd", 32'(bus.bcd), 0);
    check("t5_rst_ovf", 32'(bus.overflow), 0);
    tick();
    tick();
    rst_n = 1'b1;
    count_dones(30, dones);
    check("t5_no_done", 32'(dones), 0);
    check("t5_no_busy", 32'(bus.busy), 0);
    check("t5_bcd_kept", 32'(bus.bcd), 0);

    bus.value = 14'd42;
    count_dones(20, dones);
    check("no_auto", 32'(dones), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
